// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG byte reader.
// Holds the default generics (sample divider, output FIFO depth,
// repetition-count limit) and the byte type used on the data path.
package trng_pkg;

    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_REP_LIMIT  = 31;

    typedef logic [7:0] trng_byte_t;

endpackage

// File: rtl/trng_sync_fifo.sv
// Small synchronous byte FIFO with show-ahead output.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset of pointers/level
//   push        - write push_data (accepted when not full, or when a pop
//                 happens in the same cycle)
//   pop         - remove head entry (ignored when empty)
//   flush       - discard all entries; overrides push and pop
//   full, empty - status flags
//   level       - number of stored entries
//   pop_data    - head entry, forced to 0 while empty
module trng_sync_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trng_byte_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output trng_byte_t               pop_data
);

    localparam int AW = $clog2(DEPTH);

    trng_byte_t          mem [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         level_reg;
    logic                do_push;
    logic                do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    assign level    = level_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/trng_byte_reader.sv
// TRNG byte reader: synchronizes a ring-oscillator bit, decimates it,
// whitens it with a Von Neumann extractor, packs accepted bits MSB-first
// into bytes and queues them in a small FIFO. A repetition-count health
// test latches a failure, flushes the FIFO and blocks further output.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - block enable (0 clears the sampling/packing path)
//   raw_bit      - asynchronous entropy bit
//   rd_ready     - consumer takes rd_data this cycle
//   rd_valid     - rd_data holds an unread byte
//   rd_data      - oldest stored byte (0 when empty)
//   fifo_level   - bytes stored
//   overflow     - sticky, a byte was dropped on a full FIFO
//   health_fail  - sticky, repetition-count test failed
module trng_byte_reader
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          raw_bit,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          health_fail
);

    logic [1:0]  sync_reg;
    logic [7:0]  div_cnt_reg;
    logic        phase_reg;        // 0: next sample is first of a pair
    logic        first_bit_reg;
    trng_byte_t  shift_reg;
    logic [2:0]  bit_cnt_reg;
    logic        push_pending_reg;
    trng_byte_t  push_data_reg;
    logic [7:0]  rep_cnt_reg;      // 0 means no sample seen since reset/enable
    logic        prev_sample_reg;
    logic        overflow_reg;
    logic        health_fail_reg;

    logic        sample;
    logic        tick;
    logic        accept;
    logic        rep_trip;
    logic        flush;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign sample   = sync_reg[1];
    assign tick     = ena && (div_cnt_reg == 8'(SAMPLE_DIV - 1));
    assign accept   = tick && phase_reg && (first_bit_reg != sample);
    assign rep_trip = (rep_cnt_reg == 8'(REP_LIMIT));
    // Flush on the trip cycle too, so the FIFO is empty as health_fail rises.
    assign flush     = rep_trip || health_fail_reg;
    assign fifo_push = push_pending_reg && !flush;
    assign rd_valid  = !fifo_empty && !health_fail_reg;
    assign fifo_pop  = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg      <= '0;
            phase_reg        <= 1'b0;
            first_bit_reg    <= 1'b0;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            push_pending_reg <= 1'b0;
            push_data_reg    <= '0;
            rep_cnt_reg      <= '0;
            prev_sample_reg  <= 1'b0;
        end else begin
            // A completed byte is still handed to the FIFO if ena drops.
            push_pending_reg <= accept && (bit_cnt_reg == 3'd7);
            if (accept && (bit_cnt_reg == 3'd7)) begin
                push_data_reg <= {shift_reg[6:0], first_bit_reg};
            end
            if (!ena) begin
                div_cnt_reg   <= '0;
                phase_reg     <= 1'b0;
                first_bit_reg <= 1'b0;
                shift_reg     <= '0;
                bit_cnt_reg   <= '0;
                rep_cnt_reg   <= '0;
            end else begin
                div_cnt_reg <= tick ? 8'd0 : div_cnt_reg + 8'd1;
                if (tick) begin
                    phase_reg       <= !phase_reg;
                    prev_sample_reg <= sample;
                    if (!phase_reg) begin
                        first_bit_reg <= sample;
                    end
                    if (rep_cnt_reg == 8'd0 || sample != prev_sample_reg) begin
                        rep_cnt_reg <= 8'd1;
                    end else if (!rep_trip) begin
                        rep_cnt_reg <= rep_cnt_reg + 8'd1;
                    end
                end
                if (accept) begin
                    shift_reg   <= {shift_reg[6:0], first_bit_reg};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg    <= 1'b0;
            health_fail_reg <= 1'b0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
            if (rep_trip) begin
                health_fail_reg <= 1'b1;
            end
        end
    end

    trng_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data_reg),
        .pop       (fifo_pop),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .pop_data  (rd_data)
    );

    assign overflow    = overflow_reg;
    assign health_fail = health_fail_reg;

endmodule

// File: tb/tb_trng_byte_reader.sv
module tb_trng_byte_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       raw_bit;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       health_fail;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    bit         model_hf  = 1'b0;

    always #5 clk = ~clk;

    trng_byte_reader #(
        .SAMPLE_DIV (1),
        .FIFO_DEPTH (4),
        .REP_LIMIT  (31)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .raw_bit     (raw_bit),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Von Neumann encoding of a byte: 1 -> pair 10, 0 -> pair 01, MSB first.
    function automatic logic [15:0] enc(input logic [7:0] b);
        logic [15:0] s;
        for (int k = 0; k < 8; k++) begin
            s[15-2*k -: 2] = b[7-k] ? 2'b10 : 2'b01;
        end
        return s;
    endfunction

    // Drives 'len' samples (MSB of bits[len-1:0] first) with SAMPLE_DIV=1,
    // then updates the scoreboard with the bytes the stream must produce.
    task automatic run_stream(input logic [63:0] bits, input int len,
                              input bit chk_lat, input bit pop_at_push, input bit keep_ena);
        logic [7:0] acc;
        int         nacc;
        logic [7:0] made[$];
        acc  = 8'h00;
        nacc = 0;
        for (int p = 0; p + 1 < len; p += 2) begin
            if (bits[len-1-p] != bits[len-2-p]) begin
                acc = {acc[6:0], bits[len-1-p]};
                nacc++;
                if (nacc == 8) begin
                    made.push_back(acc);
                    nacc = 0;
                end
            end
        end
        // Enabling two cycles late aligns the first tick with the first
        // bit emerging from the synchronizer.
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            raw_bit = bits[len-1-i];
            if (i == 2) ena = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if (!keep_ena) ena = 1'b0;
        if (chk_lat) check("lat_n1_valid", rd_valid, 1'b0);
        if (pop_at_push) begin
            check("pop_at_push_data", rd_data, model_q[0]);
            rd_ready = 1'b1;
        end
        @(negedge clk);
        rd_ready = 1'b0;
        if (chk_lat) check("lat_n2_valid", rd_valid, 1'b1);
        if (pop_at_push) void'(model_q.pop_front());
        foreach (made[k]) begin
            if (!model_hf) begin
                if (model_q.size() < 4) model_q.push_back(made[k]);
                else model_ovf = 1'b1;
            end
        end
        $display("stream len=%0d bytes=%0d level=%0d ovf=%0b hf=%0b",
                 len, made.size(), fifo_level, overflow, health_fail);
    endtask

    task automatic read_expect(input string tag);
        logic [7:0] exp;
        int c;
        c = 0;
        while (!rd_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_valid"}, rd_valid, 1'b1);
        exp = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
        check({tag, "_data"}, rd_data, exp);
        $display("read %s data=%02h expected=%02h", tag, rd_data, exp);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        model_hf  = 1'b0;
        $display("reset pulse done");
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b0;
        raw_bit  = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_hf", health_fail, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Alternating pairs 10,01 -> 0xAA with two-cycle push latency.
        run_stream(64'h9999, 16, 1'b1, 1'b0, 1'b0);
        read_expect("aa");
        check("aa_level_after", fifo_level, 3'd0);

        // Discarded 00/11 pairs interleaved with 01 pairs -> only 0x00.
        run_stream(64'h1D1D55, 24, 1'b0, 1'b0, 1'b0);
        check("zero_level", fifo_level, 3'd1);
        read_expect("zero");
        check("zero_level_after", fifo_level, 3'd0);

        // Five bytes without reading: one dropped, overflow sticky.
        for (int b = 1; b <= 5; b++) run_stream({48'h0, enc(8'(b))}, 16, 1'b0, 1'b0, 1'b0);
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_flag", overflow, model_ovf);
        for (int b = 1; b <= 4; b++) read_expect($sformatf("ovf_rd%0d", b));
        check("ovf_drained_valid", rd_valid, 1'b0);
        check("ovf_drained_data", rd_data, 8'h00);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        check("reset_clears_ovf", overflow, 1'b0);
        for (int b = 1; b <= 4; b++) run_stream({48'h0, enc(8'(b * 8'h11))}, 16, 1'b0, 1'b0, 1'b0);
        check("full_level", fifo_level, 3'd4);
        run_stream({48'h0, enc(8'h55)}, 16, 1'b0, 1'b1, 1'b0);
        check("pushpop_level", fifo_level, 3'd4);
        check("pushpop_ovf", overflow, model_ovf);
        for (int b = 1; b <= 4; b++) read_expect($sformatf("pp_rd%0d", b));

        // Repetition failure: 31 equal samples flush and block output.
        run_stream({48'h0, enc(8'h5A)}, 16, 1'b0, 1'b0, 1'b0);
        check("pre_hf_level", fifo_level, 3'd1);
        run_stream(64'h7FFF_FFFF, 31, 1'b0, 1'b0, 1'b0);
        model_hf = 1'b1;
        model_q.delete();
        check("hf_set", health_fail, model_hf);
        check("hf_valid", rd_valid, 1'b0);
        check("hf_level", fifo_level, 3'd0);
        run_stream({48'h0, enc(8'hC3)}, 16, 1'b0, 1'b0, 1'b0);
        check("hf_no_push_level", fifo_level, 3'd0);
        check("hf_no_push_valid", rd_valid, 1'b0);
        do_reset();
        check("hf_cleared", health_fail, 1'b0);

        // Reset in the middle of a byte discards the partial bits.
        run_stream({48'h0, enc(8'h55)}, 16, 1'b0, 1'b0, 1'b0);
        check("mid_pre_level", fifo_level, 3'd1);
        run_stream(64'h155, 10, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rd_valid, 1'b0);
        check("mid_rst_data", rd_data, 8'h00);
        check("mid_rst_level", fifo_level, 3'd0);
        ena = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_stream({48'h0, enc(8'hFF)}, 16, 1'b0, 1'b0, 1'b0);
        check("mid_post_level", fifo_level, 3'd1);
        read_expect("ff");
        check("mid_final_level", fifo_level, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
